stream_rsp_buffer: RTL and testbench
====================================

// Module: stream_rsp_buffer
// PURPOSE
// - Response-path buffer downstream of the credit-based request throttle.
// - Stores up to Depth responses from the slave and presents them in order to the master.
// - Emits one credit-release pulse per response that leaves the buffer, either popped or flushed.
//   The pulse drives the throttle's response handshake: rsp_valid_i = rel_o, rsp_ready_i = 1.
// - With the throttle's credit_i <= Depth, the buffer never overflows.
// PARAMETERS
// - Depth      4   number of response entries; >= 1; need not be a power of two
// - DataWidth  32  response payload width in bits
// - CntWidth   cf_math_pkg::idx_width(Depth+1)  occupancy counter width (DO NOT OVERWRITE)
// PORTS
// - clk_i       in   1          clock
// - rst_ni      in   1          asynchronous reset, active low
// - flush_i     in   1          discard all stored entries, returning their credits
// - in_valid_i  in   1          response valid from slave
// - in_ready_o  out  1          buffer can accept a response
// - in_data_i   in   DataWidth  response payload
// - out_valid_o out  1          response available to master
// - out_ready_i in   1          master accepts response
// - out_data_o  out  DataWidth  head-of-buffer payload
// - rel_o       out  1          credit release pulse, one per departing entry
// - usage_o     out  CntWidth   number of stored entries, 0..Depth
// BEHAVIOUR
// - Reset (async, rst_ni=0): state=RUN; rd_ptr=0, wr_ptr=0, count=0.
//   Outputs under reset: in_ready_o=1, out_valid_o=0, rel_o=0, usage_o=0.
//   Payload storage is not reset.
// - Reset mid-DRAIN: state returns to RUN and count goes to 0 immediately. Remaining releases
//   are dropped; the throttle shares rst_ni, so its counter clears in the same event.
// - State RUN, flush_i=0:
//   - in_ready_o = (count < Depth); push = in_valid_i & in_ready_o.
//   - out_valid_o = (count != 0); out_data_o = mem[rd_ptr]; pop = out_valid_o & out_ready_i.
//   - rel_o = pop (combinational, same cycle as the pop handshake).
//   - No fall-through: an entry pushed in cycle N is first visible on out_* in cycle N+1.
//   - push & pop in the same cycle: count unchanged, both pointers advance.
//   - Full (count==Depth): in_ready_o=0 even if a pop occurs that cycle; no bypass.
//   - Empty: out_valid_o=0 and rel_o=0, even if a push occurs that cycle.
//   - Pointers wrap Depth-1 -> 0. count is updated as count + push - pop.
// - State RUN, flush_i=1 (flush wins over everything):
//   - in_ready_o=0, out_valid_o=0, rel_o=0; no push or pop takes place.
//   - If count==0: stay in RUN, pointers reset to 0, no release.
//   - Else: go to DRAIN.
// - State DRAIN:
//   - in_ready_o=0, out_valid_o=0, rel_o=1 every cycle; count decrements by 1 per cycle.
//   - flush_i is ignored.
//   - In the cycle count==1: the final release is issued; next cycle state=RUN, count=0,
//     rd_ptr=wr_ptr=0.
//   - Total rel_o pulses = entries held at flush; at most one release per cycle.
// - usage_o = count, registered; it reflects state after the previous edge.
// - out_data_o is stable while out_valid_o=1 and out_ready_i=0.
// - Assertions:
//   - never push when count==Depth; never pop when count==0;
//   - rel_o count over time equals pops + flushed entries.
// TESTING
// - Depth=4, out_ready_i=0, push A,B,C,D:
//   -> in_ready_o=0 after the 4th edge, usage_o=4, out_data_o=A, rel_o=0 throughout.
// - Then out_ready_i=1 for 4 cycles:
//   -> out_data_o A,B,C,D in order, rel_o=1 each cycle, usage_o ends at 0.
// - count=2, push and pop in the same cycle for 5 cycles:
//   -> usage_o stays 2, data order preserved, rel_o=1 each cycle.
// - Depth=3, 10 pushes/pops interleaved:
//   -> pointers wrap correctly, payload order 0..9 exact.
// - 3 entries stored, flush_i pulsed 1 cycle (out_ready_i=1):
//   -> no pop that cycle, then rel_o=1 for exactly 3 cycles with in_ready_o=0.
//   -> Back in RUN with usage_o=0, in_ready_o=1.
// - rst_ni asserted in the 2nd DRAIN cycle:
//   -> rel_o=0 and usage_o=0 immediately.
//   -> After release, a normal push/pop works from pointer 0.

Source files
------------

// File: rtl/stream_rsp_buffer.sv
// stream_rsp_buffer: in-order response buffer that emits one credit release per departing entry
module stream_rsp_buffer #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = (Depth + 1 > 1) ? $clog2(Depth + 1) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 rel_o,
  output logic [CntWidth-1:0]  usage_o
);
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(Depth - 1);
  localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);
  typedef enum logic {RUN, DRAIN} state_e;
  state_e state_q, state_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0] mem_q [Depth];
  logic push, pop;
  always_comb begin
    state_d = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d = cnt_q;
    in_ready_o = 1'b0;
    out_valid_o = 1'b0;
    rel_o = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    if (state_q == DRAIN) begin
      rel_o = 1'b1;
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        state_d = RUN;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end
    end else if (flush_i) begin
      if (cnt_q == '0) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end else begin
        state_d = DRAIN;
      end
    end else begin
      in_ready_o = cnt_q != CntFull;
      out_valid_o = cnt_q != '0;
      push = in_valid_i & in_ready_o;
      pop = out_valid_o & out_ready_i;
      rel_o = pop;
      wr_ptr_d = push ? ((wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne) : wr_ptr_q;
      rd_ptr_d = pop ? ((rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne) : rd_ptr_q;
      cnt_d = cnt_q + CntWidth'(push) - CntWidth'(pop);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end
  assign out_data_o = mem_q[rd_ptr_q];
  assign usage_o = cnt_q;
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && cnt_q == CntFull));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && cnt_q == '0));
endmodule

// File: tb/tb_stream_rsp_buffer.sv
// tb_stream_rsp_buffer: scoreboard bench for Depth=4 and Depth=3 response buffers
module tb_stream_rsp_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic f4, v4, r4, u4_ir, u4_ov, u4_rel;
  logic [31:0] d4, u4_dout;
  logic [2:0] u4_use;
  logic f3, v3, r3, u3_ir, u3_ov, u3_rel;
  logic [31:0] d3, u3_dout;
  logic [1:0] u3_use;
  logic [31:0] q4[$];
  logic [31:0] q3[$];
  int tests = 0, fails = 0;
  int rel4 = 0, pop4 = 0, pop3 = 0, cnt3 = 0, nd = 0;
  always #5 clk = ~clk;
  stream_rsp_buffer #(.Depth(4), .DataWidth(32)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f4), .in_valid_i(v4), .in_ready_o(u4_ir),
    .in_data_i(d4), .out_valid_o(u4_ov), .out_ready_i(r4), .out_data_o(u4_dout),
    .rel_o(u4_rel), .usage_o(u4_use)
  );
  stream_rsp_buffer #(.Depth(3), .DataWidth(32)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .in_valid_i(v3), .in_ready_o(u3_ir),
    .in_data_i(d3), .out_valid_o(u3_ov), .out_ready_i(r3), .out_data_o(u3_dout),
    .rel_o(u3_rel), .usage_o(u3_use)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step4(input logic v, input logic [31:0] d, input logic r, input logic f,
                       input logic er, input logic erel, input int eu);
    @(posedge clk);
    #1 v4 = v; d4 = d; r4 = r; f4 = f;
    @(negedge clk);
    check("u4_in_ready", u4_ir, er);
    check("u4_rel", u4_rel, erel);
    check("u4_usage", u4_use, eu);
    if (f) q4.delete();
    if (v && er && !f) q4.push_back(d);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (u4_rel) rel4++;
      if (u4_ov && r4) begin
        pop4++;
        if (q4.size() == 0) begin
          tests++; fails++;
          $display("FAIL u4_data: got %0h, expected no pop", u4_dout);
        end else check("u4_data", u4_dout, q4.pop_front());
      end
      if (u3_ov && r3) begin
        pop3++;
        if (q3.size() == 0) begin
          tests++; fails++;
          $display("FAIL u3_data: got %0h, expected no pop", u3_dout);
        end else check("u3_data", u3_dout, q3.pop_front());
      end
    end
  end
  initial begin
    {f4, v4, r4, f3, v3, r3} = '0;
    d4 = '0; d3 = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", u4_ir, 1); check("rst_out_valid", u4_ov, 0);
    check("rst_rel", u4_rel, 0); check("rst_usage", u4_use, 0);
    check("rst3_in_ready", u3_ir, 1); check("rst3_usage", u3_use, 0);
    rst_n = 1'b1;
    // fill to full with master stalled
    for (int i = 0; i < 4; i++) step4(1, 32'hA0 + i, 0, 0, 1, 0, i);
    step4(0, 0, 0, 0, 0, 0, 4);
    check("full_head", u4_dout, 32'hA0); check("full_valid", u4_ov, 1);
    step4(1, 32'hEE, 0, 0, 0, 0, 4);
    check("stable_head", u4_dout, 32'hA0);
    for (int i = 0; i < 4; i++) step4(0, 0, 1, 0, i != 0, 1, 4 - i);
    step4(0, 0, 0, 0, 1, 0, 0);
    // steady state at occupancy 2 with push and pop each cycle
    step4(1, 32'hB0, 0, 0, 1, 0, 0);
    step4(1, 32'hB1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step4(1, 32'hB2 + i, 1, 0, 1, 1, 2);
    step4(0, 0, 1, 0, 1, 1, 2);
    step4(0, 0, 1, 0, 1, 1, 1);
    step4(0, 0, 0, 0, 1, 0, 0);
    // flush of 3 entries, flush_i reasserted mid-drain is ignored
    for (int i = 0; i < 3; i++) step4(1, 32'hC0 + i, 0, 0, 1, 0, i);
    step4(0, 0, 1, 1, 0, 0, 3);
    step4(0, 0, 1, 0, 0, 1, 3);
    step4(0, 0, 1, 1, 0, 1, 2);
    step4(0, 0, 1, 0, 0, 1, 1);
    step4(0, 0, 0, 0, 1, 0, 0);
    step4(0, 0, 0, 1, 0, 0, 0);
    step4(0, 0, 0, 0, 1, 0, 0);
    // reset arriving in the second drain cycle
    for (int i = 0; i < 3; i++) step4(1, 32'hD0 + i, 0, 0, 1, 0, i);
    step4(0, 0, 0, 1, 0, 0, 3);
    step4(0, 0, 0, 0, 0, 1, 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rel", u4_rel, 0); check("mid_rst_usage", u4_use, 0);
    check("mid_rst_in_ready", u4_ir, 1); check("mid_rst_out_valid", u4_ov, 0);
    rst_n = 1'b1;
    q4.delete();
    step4(1, 32'hE0, 0, 0, 1, 0, 0);
    step4(0, 0, 0, 0, 1, 0, 1);
    check("post_rst_head", u4_dout, 32'hE0);
    step4(0, 0, 1, 0, 1, 1, 1);
    step4(0, 0, 0, 0, 1, 0, 0);
    check("u4_pops", pop4, 12);
    check("u4_rel_total", rel4, pop4 + 4);
    // Depth=3: interleaved traffic against a small occupancy model
    for (int c = 0; c < 60 && (nd < 10 || cnt3 != 0); c++) begin
      logic v, r, er, p, o;
      v = (nd < 10) && (c % 3 != 2);
      r = (c % 4 != 0) && (c > 3);
      @(posedge clk);
      #1 v3 = v; d3 = nd; r3 = r;
      @(negedge clk);
      er = cnt3 != 3;
      p = v && er;
      o = r && cnt3 != 0;
      check("u3_in_ready", u3_ir, er);
      check("u3_rel", u3_rel, o);
      check("u3_usage", u3_use, cnt3);
      if (p) begin
        q3.push_back(nd);
        nd++;
      end
      cnt3 = cnt3 + int'(p) - int'(o);
    end
    @(posedge clk);
    #1 v3 = 0; r3 = 0;
    check("u3_pushed", nd, 10);
    check("u3_pops", pop3, 10);
    check("u3_final_usage", u3_use, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
